// File: rtl/alu_op_sequencer.sv
// Multicycle issue/writeback stage around the 13-bit ALU with a 4-entry register file.
// Optional zero/negative flag outputs are enabled by defining ALU_SEQ_FLAGS_EN.
module alu_op_sequencer #(
  parameter int unsigned DATA_W   = 13,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [9:0]        in_instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [1:0]        res_rd,
  output logic              res_illegal,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n
`endif
);

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic              rf_we_c;

  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              we_q, we_d;
  logic              in_ready_q, in_ready_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [ADDR_W-1:0] res_rd_q, res_rd_d;
  logic              res_illegal_q, res_illegal_d;
`ifdef ALU_SEQ_FLAGS_EN
  logic              flag_z_q, flag_z_d;
  logic              flag_n_q, flag_n_d;
`endif

  logic [OP_W-1:0]   op_c;
  logic [ADDR_W-1:0] rd_c, rs1_c, rs2_c;
  logic [SEL_W-1:0]  dec_sel_c;
  logic              dec_we_c;
  logic              accept_c;

  assign op_c     = in_instr[9:6];
  assign rd_c     = in_instr[5:4];
  assign rs1_c    = in_instr[3:2];
  assign rs2_c    = in_instr[1:0];
  assign accept_c = in_valid && in_ready_q && (state_q == S_IDLE);

  // Opcode decode; anything outside the four supported ops clears and suppresses writeback.
  always_comb begin
    dec_sel_c = 4'b0101;
    dec_we_c  = 1'b0;
    case (op_c)
      4'b0000: begin dec_sel_c = 4'b0001; dec_we_c = 1'b1; end
      4'b0001: begin dec_sel_c = 4'b0010; dec_we_c = 1'b1; end
      4'b0010: begin dec_sel_c = 4'b0011; dec_we_c = 1'b1; end
      4'b0011: begin dec_sel_c = 4'b0100; dec_we_c = 1'b1; end
      default: begin dec_sel_c = 4'b0101; dec_we_c = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for registered outputs; operands come from the pre-write register file.
  always_comb begin
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_sel_d     = alu_sel_q;
    rd_d          = rd_q;
    we_d          = we_q;
    res_data_d    = res_data_q;
    res_rd_d      = res_rd_q;
    res_illegal_d = res_illegal_q;
    rf_we_c       = 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
    flag_z_d      = flag_z_q;
    flag_n_d      = flag_n_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          alu_a_d   = rf_q[rs1_c];
          alu_b_d   = rf_q[rs2_c];
          alu_sel_d = dec_sel_c;
          rd_d      = rd_c;
          we_d      = dec_we_c;
        end
      end
      S_EXEC: begin
        res_data_d    = alu_result;
        res_rd_d      = rd_q;
        res_illegal_d = !we_q;
        rf_we_c       = we_q;
`ifdef ALU_SEQ_FLAGS_EN
        if (we_q) begin
          flag_z_d = (alu_result == '0);
          flag_n_d = alu_result[DATA_W-1];
        end
`endif
      end
      S_WB: begin
        alu_sel_d = '0;
      end
      default: ;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    res_valid_d = (state_d == S_WB);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_sel_q     <= '0;
      rd_q          <= '0;
      we_q          <= 1'b0;
      in_ready_q    <= 1'b1;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_rd_q      <= '0;
      res_illegal_q <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      flag_z_q      <= 1'b0;
      flag_n_q      <= 1'b0;
`endif
    end else begin
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_sel_q     <= alu_sel_d;
      rd_q          <= rd_d;
      we_q          <= we_d;
      in_ready_q    <= in_ready_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_rd_q      <= res_rd_d;
      res_illegal_q <= res_illegal_d;
`ifdef ALU_SEQ_FLAGS_EN
      flag_z_q      <= flag_z_d;
      flag_n_q      <= flag_n_d;
`endif
    end
  end

  // Register file: written with the live ALU result at the end of EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) rf_q[i] <= '0;
    end else if (rf_we_c) begin
      rf_q[rd_q] <= alu_result;
    end
  end

  assign in_ready    = in_ready_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_rd      = res_rd_q;
  assign res_illegal = res_illegal_q;
  assign dbg_data    = rf_q[dbg_addr];
`ifdef ALU_SEQ_FLAGS_EN
  assign flag_z      = flag_z_q;
  assign flag_n      = flag_n_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU; an override lets the bench
// write arbitrary constants into the register file through the normal instruction path.
module tb_alu_op_sequencer;

  localparam int unsigned DW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [9:0]    in_instr;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [3:0]    alu_sel;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [1:0]    res_rd;
  logic          res_illegal;
  logic [1:0]    dbg_addr;
  logic [DW-1:0] dbg_data;
`ifdef ALU_SEQ_FLAGS_EN
  logic          flag_z, flag_n;
`endif

  logic          ovr_en;
  logic [DW-1:0] ovr_val;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    rd;
    logic          ill;
    logic          z;
    logic          n;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_z = 1'b0;
  logic exp_n = 1'b0;

  alu_op_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_rd     (res_rd),
    .res_illegal(res_illegal),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flag_z     (flag_z),
    .flag_n     (flag_n)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU: 1 add, 2 sub, 3 and, 4 or, everything else clears.
  always_comb begin
    if (ovr_en) alu_result = ovr_val;
    else begin
      case (alu_sel)
        4'd1:    alu_result = DW'(alu_a + alu_b);
        4'd2:    alu_result = DW'(alu_a - alu_b);
        4'd3:    alu_result = alu_a & alu_b;
        4'd4:    alu_result = alu_a | alu_b;
        default: alu_result = '0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic [1:0] rd, input logic ill);
    if (!ill) begin
      exp_z = (d == '0);
      exp_n = d[DW-1];
    end
    sb_q.push_back('{data: d, rd: rd, ill: ill, z: exp_z, n: exp_n});
  endtask

  // Presents one instruction and returns #1 after the accepting edge (inside EXEC).
  task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2);
    @(negedge clk);
    check("ready_before_issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_instr = {op, rd, rs1, rs2};
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // From EXEC: checks the WB pulse timing and the written register, then returns in IDLE.
  task automatic finish(input logic [1:0] reg_a, input logic [DW-1:0] reg_exp);
    @(posedge clk);
    #1;
    check("res_valid_latency", 32'(res_valid), 32'd1);
    check("in_ready_in_wb", 32'(in_ready), 32'd0);
    dbg_addr = reg_a;
    #1;
    check("dbg_after_write", 32'(dbg_data), 32'(reg_exp));
    @(posedge clk);
    #1;
    check("res_valid_one_cycle", 32'(res_valid), 32'd0);
  endtask

  task automatic preload(input logic [1:0] rd, input logic [DW-1:0] val);
    ovr_en  = 1'b1;
    ovr_val = val;
    push_exp(val, rd, 1'b0);
    send(4'd0, rd, 2'd0, 2'd0);
    finish(rd, val);
    ovr_en  = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && res_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_res_valid: got res_valid=1 with no pending instruction");
        end else begin
          e = sb_q.pop_front();
          check("res_data", 32'(res_data), 32'(e.data));
          check("res_rd", 32'(res_rd), 32'(e.rd));
          check("res_illegal", 32'(res_illegal), 32'(e.ill));
`ifdef ALU_SEQ_FLAGS_EN
          check("flag_z", 32'(flag_z), 32'(e.z));
          check("flag_n", 32'(flag_n), 32'(e.n));
`endif
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    dbg_addr = '0;
    ovr_en   = 1'b0;
    ovr_val  = '0;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      check("reset_dbg", 32'(dbg_data), 32'd0);
    end
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_alu_sel", 32'(alu_sel), 32'd0);
    check("reset_res_data", 32'(res_data), 32'd0);

    preload(2'd1, 13'd5);
    preload(2'd2, 13'd3);

    // r3 = r1 - r2 = 2
    push_exp(13'd2, 2'd3, 1'b0);
    send(4'b0001, 2'd3, 2'd1, 2'd2);
    check("exec_alu_sel_sub", 32'(alu_sel), 32'h2);
    check("exec_alu_a", 32'(alu_a), 32'd5);
    check("exec_alu_b", 32'(alu_b), 32'd3);
    check("exec_in_ready", 32'(in_ready), 32'd0);
    finish(2'd3, 13'd2);
    check("idle_alu_sel", 32'(alu_sel), 32'd0);

    // r0 = 0 - 1 wraps to 1FFF (negative, non-zero)
    preload(2'd1, 13'd1);
    push_exp(13'h1FFF, 2'd0, 1'b0);
    send(4'b0001, 2'd0, 2'd0, 2'd1);
    finish(2'd0, 13'h1FFF);

    // Illegal opcode: clear select, no writeback, r1 stays 1
    push_exp(13'd0, 2'd1, 1'b1);
    send(4'b0111, 2'd1, 2'd1, 2'd2);
    check("exec_alu_sel_illegal", 32'(alu_sel), 32'h5);
    finish(2'd1, 13'd1);

    // in_valid held high: r3 = r1 | r2 = 3, accepted every third edge
    for (int k = 0; k < 3; k++) push_exp(13'd3, 2'd3, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = {4'b0011, 2'd3, 2'd1, 2'd2};
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      check("throughput_in_ready", 32'(in_ready), (k % 3 == 2) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    check("throughput_drained", 32'(sb_q.size()), 32'd0);

    // r2 = r2 + r2 with r2 = 7 as both source and destination
    preload(2'd2, 13'd7);
    push_exp(13'd14, 2'd2, 1'b0);
    send(4'b0000, 2'd2, 2'd2, 2'd2);
    check("exec_alu_sel_add", 32'(alu_sel), 32'h1);
    finish(2'd2, 13'd14);

    // Reset while in EXEC: no completion, everything cleared
    send(4'b0000, 2'd1, 2'd2, 2'd2);
    rst = 1'b1;
    #2;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_alu_sel", 32'(alu_sel), 32'd0);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    rst   = 1'b0;
    exp_z = 1'b0;
    exp_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      check("midrst_dbg", 32'(dbg_data), 32'd0);
    end
    repeat (4) @(posedge clk);
    #1;
    check("midrst_res_data", 32'(res_data), 32'd0);

    // Zero result after reset
    push_exp(13'd0, 2'd0, 1'b0);
    send(4'b0000, 2'd0, 2'd0, 2'd0);
    finish(2'd0, 13'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
